// File: rtl/plot_sink.sv
// Plot request sink: validates and buffers processor plot requests, then issues
// one framebuffer write per request under fb_ready pacing; includes a full-screen clear sweep.
module plot_sink #(
  parameter int         WIDTH      = 160,
  parameter int         HEIGHT     = 120,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot_en,
  input  logic [7:0]  plot_x,
  input  logic [7:0]  plot_y,
  input  logic [2:0]  plot_colour,
  input  logic        clear_req,
  input  logic        fb_ready,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [7:0]       X_LIM     = 8'(WIDTH);
  localparam logic [7:0]       Y_LIM     = 8'(HEIGHT);
  localparam logic [14:0]      LAST_ADDR = 15'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
  } req_t;

  // Row stride of 160 expressed as 128 + 32 so no multiplier is needed.
  function automatic logic [14:0] pixel_addr(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] y15;
    y15 = {7'b0000000, y};
    return (y15 << 4'd7) + (y15 << 4'd5) + {7'b0000000, x};
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  req_t              fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              fb_we_r;
  logic [14:0]       fb_addr_r;
  logic [2:0]        fb_data_r;
  logic [7:0]        drop_count_r;

  req_t              head_s;
  logic              full_s;
  logic              in_range_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  logic              drop_s;
  logic              we_next_s;
  logic [14:0]       addr_next_s;
  logic [2:0]        data_next_s;

  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign full_s     = (count_r == FULL_CNT);
  assign in_range_s = (plot_x < X_LIM) && (plot_y < Y_LIM);
  // Any request that is not pushed is a discard: range, full, clear start or sweep.
  assign drop_s     = plot_en && !push_s;

  assign fb_we      = fb_we_r;
  assign fb_addr    = fb_addr_r;
  assign fb_data    = fb_data_r;
  assign drop_count = drop_count_r;
  assign busy       = (state_r == ST_CLEAR) || (count_r != CNT_ZERO) || fb_we_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, FIFO control and output-register next values.
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    flush_s      = 1'b0;
    we_next_s    = fb_we_r;
    addr_next_s  = fb_addr_r;
    data_next_s  = fb_data_r;
    case (state_r)
      ST_CLEAR: begin
        if (fb_we_r && fb_ready) begin
          if (fb_addr_r == LAST_ADDR) begin
            we_next_s    = 1'b0;
            state_next_s = ST_IDLE;
          end else begin
            addr_next_s = fb_addr_r + 15'd1;
          end
        end else begin
          we_next_s = fb_we_r;
        end
      end
      ST_IDLE, ST_DRAIN: begin
        if (clear_req) begin
          flush_s      = 1'b1;
          state_next_s = ST_CLEAR;
          we_next_s    = 1'b1;
          addr_next_s  = 15'd0;
          data_next_s  = BG_COLOUR;
        end else begin
          push_s = plot_en && in_range_s && !full_s;
          if (!fb_we_r || fb_ready) begin
            if (count_r != CNT_ZERO) begin
              pop_s       = 1'b1;
              we_next_s   = 1'b1;
              addr_next_s = pixel_addr(head_s.x, head_s.y);
              data_next_s = head_s.colour;
            end else begin
              we_next_s = 1'b0;
            end
          end else begin
            we_next_s = fb_we_r;
          end
          // DRAIN while anything remains queued or in the output register.
          if (push_s || we_next_s || (count_r > CNT_W'(pop_s))) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        we_next_s    = 1'b0;
      end
    endcase
  end

  // Request FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '{x: 8'd0, y: 8'd0, colour: 3'd0};
      end
    end else if (flush_s) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= '{x: plot_x, y: plot_y, colour: plot_colour};
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Framebuffer write output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_we_r   <= 1'b0;
      fb_addr_r <= 15'd0;
      fb_data_r <= 3'd0;
    end else begin
      fb_we_r   <= we_next_s;
      fb_addr_r <= addr_next_s;
      fb_data_r <= data_next_s;
    end
  end

  // Saturating discard counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_r <= 8'd0;
    end else if (drop_s && (drop_count_r != 8'hFF)) begin
      drop_count_r <= drop_count_r + 8'd1;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: directed test-plan scenarios plus random
// stimulus, compared cycle by cycle against a queue-based reference model.
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        plot_en;
  logic [7:0]  plot_x;
  logic [7:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        clear_req;
  logic        fb_ready;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        busy;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  plot_sink dut (
    .clk        (clk),
    .reset      (reset),
    .plot_en    (plot_en),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_colour(plot_colour),
    .clear_req  (clear_req),
    .fb_ready   (fb_ready),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .busy       (busy),
    .drop_count (drop_count)
  );

  typedef struct {
    int addr;
    int data;
  } pix_t;

  // Reference model: pending requests in a queue, one held output write, clear flag.
  pix_t mq[$];
  bit   m_we;
  int   m_addr;
  int   m_data;
  int   m_drop;
  bit   m_clear;
  int   wlog[$];
  int   wdat[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 0; m_addr = 0; m_data = 0; m_drop = 0; m_clear = 0;
  endtask

  task automatic model_edge();
    bit   full;
    bit   acc;
    pix_t p;
    full = (mq.size() == 4);
    if (m_clear) begin
      if (plot_en) m_drop++;
      if (m_we && fb_ready) begin
        if (m_addr == 160 * 120 - 1) begin
          m_we = 0; m_clear = 0;
        end else begin
          m_addr++;
        end
      end
    end else if (clear_req) begin
      if (plot_en) m_drop++;
      mq.delete();
      m_clear = 1; m_we = 1; m_addr = 0; m_data = 0;
    end else begin
      acc = plot_en && (plot_x < 160) && (plot_y < 120) && !full;
      if (plot_en && !acc) m_drop++;
      if (!m_we || fb_ready) begin
        if (mq.size() > 0) begin
          p = mq.pop_front();
          m_we = 1; m_addr = p.addr; m_data = p.data;
        end else begin
          m_we = 0;
        end
      end
      if (acc) mq.push_back('{addr: int'(plot_y) * 160 + int'(plot_x), data: int'(plot_colour)});
    end
    if (m_drop > 255) m_drop = 255;
  endtask

  task automatic compare_all();
    check("fb_we", fb_we, m_we);
    if (m_we) begin
      check("fb_addr", fb_addr, m_addr);
      check("fb_data", fb_data, m_data);
    end
    check("busy", busy, m_clear || (mq.size() != 0) || m_we);
    check("drop_count", drop_count, m_drop);
  endtask

  // One clock cycle: drive inputs, log any committed write, advance model, compare.
  task automatic cyc(input bit pe, input int x, input int y, input int c, input bit clr, input bit rdy);
    plot_en = pe; plot_x = 8'(x); plot_y = 8'(y); plot_colour = 3'(c);
    clear_req = clr; fb_ready = rdy;
    if (fb_we && fb_ready) begin
      wlog.push_back(int'(fb_addr));
      wdat.push_back(int'(fb_data));
    end
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, rdy);
  endtask

  initial begin
    int pre;
    int bad;
    bit hit;
    reset = 1'b1; plot_en = 1'b0; plot_x = 8'd0; plot_y = 8'd0; plot_colour = 3'd0;
    clear_req = 1'b0; fb_ready = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_we", fb_we, 1'b0);
    check("rst_addr", fb_addr, 15'd0);
    check("rst_data", fb_data, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_count, 8'd0);
    reset = 1'b0;
    idle(2, 1'b1);

    // Single plot: write appears in cycle N+2 only.
    cyc(1'b1, 3, 2, 5, 1'b0, 1'b1);
    check("single_n1_we", fb_we, 1'b0);
    idle(1, 1'b1);
    check("single_we", fb_we, 1'b1);
    check("single_addr", fb_addr, 15'd323);
    check("single_data", fb_data, 3'd5);
    idle(1, 1'b1);
    check("single_after_we", fb_we, 1'b0);
    check("single_after_busy", busy, 1'b0);

    // Range check.
    wlog.delete(); wdat.delete();
    cyc(1'b1, 160, 0, 1, 1'b0, 1'b1);
    cyc(1'b1, 0, 120, 2, 1'b0, 1'b1);
    cyc(1'b1, 159, 119, 3, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("range_writes", wlog.size(), 1);
    if (wlog.size() > 0) check("range_addr", wlog[0], 19199);
    check("range_drop", drop_count, 8'd2);

    // Overflow under back-pressure.
    for (int i = 0; i < 7; i++) cyc(1'b1, i, 10, i, 1'b0, 1'b0);
    check("ovf_drop", drop_count, 8'd4);
    check("ovf_held_addr", fb_addr, 15'd1600);
    wlog.delete(); wdat.delete();
    idle(8, 1'b1);
    check("ovf_writes", wlog.size(), 5);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] != 1600 + i) bad++;
    check("ovf_order", bad, 0);

    // Random plots with random stalls.
    wlog.delete(); wdat.delete();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, $urandom_range(159, 0), $urandom_range(119, 0), $urandom_range(7, 0),
          1'b0, 1'($urandom_range(1, 0)));
      for (int g = $urandom_range(2, 0); g > 0; g--) idle(1, 1'($urandom_range(1, 0)));
    end
    idle(10, 1'b1);
    check("stall_busy", busy, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(1, 0)), $urandom_range(170, 0), $urandom_range(125, 0),
          $urandom_range(7, 0), 1'b0, 1'($urandom_range(1, 0)));
    end
    idle(10, 1'b1);

    // Clear: queued plots flushed, full sweep with background colour.
    for (int i = 0; i < 3; i++) cyc(1'b1, 20 + i, 5, 7, 1'b0, 1'b0);
    pre = int'(drop_count);
    wlog.delete(); wdat.delete();
    cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
    check("clr_start_busy", busy, 1'b1);
    check("clr_start_we", fb_we, 1'b1);
    check("clr_start_addr", fb_addr, 15'd0);
    check("clr_drop_same", drop_count, 8'(pre));
    for (int k = 1; k < 19200; k++) cyc(k == 100, 1, 1, 1, 1'b0, 1'b1);
    check("clr_last_we", fb_we, 1'b1);
    check("clr_last_addr", fb_addr, 15'd19199);
    idle(1, 1'b1);
    check("clr_end_busy", busy, 1'b0);
    check("clr_end_we", fb_we, 1'b0);
    check("clr_drop_plot", drop_count, 8'(pre + 1));
    check("clr_writes", wlog.size(), 19200);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] != i || wdat[i] != 0) bad++;
    check("clr_pattern", bad, 0);

    // Reset mid-clear at address 500, then a normal plot.
    cyc(1'b0, 0, 0, 0, 1'b1, 1'b1);
    hit = 0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      if (fb_addr == 15'd500) hit = 1;
      else idle(1, 1'b1);
    end
    check("rst_mid_reached", hit, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_we", fb_we, 1'b0);
    check("rst_mid_addr", fb_addr, 15'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_drop", drop_count, 8'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3, 1'b1);
    check("rst_resume_busy", busy, 1'b0);
    cyc(1'b1, 7, 9, 6, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("post_rst_we", fb_we, 1'b1);
    check("post_rst_addr", fb_addr, 15'd1447);
    check("post_rst_data", fb_data, 3'd6);
    idle(3, 1'b1);

    // Saturation of the discard counter.
    for (int i = 0; i < 300; i++) cyc(1'b1, 200, 0, 0, 1'b0, 1'b1);
    check("drop_sat", drop_count, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
